imem_port_arbiter: RTL

- Shares one single-port, byte-writable instruction RAM between three requesters: the core instruction-fetch port, the core data-read port and the core data-write port.
- Replaces direct dual access to the RAM array in the top level. The arbiter drives a single RAM port and routes each read response back to the requester that issued it.
- Fixed priority is write > data read > fetch. A starvation guard forces a fetch through when fetch has waited too long.

---
 rtl/imem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Single-port instruction RAM arbiter: write > data read > fetch, with a
// starvation guard that promotes a long-waiting fetch to top priority.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH+1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH+1:0] wr_addr,
    input  logic [3:0]            wr_strb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_RD   = 2'd2
    } resp_sel_t;

    logic [3:0]            if_wait_cnt_reg;
    logic [3:0]            if_wait_cnt_next;
    resp_sel_t             resp_sel_reg;
    resp_sel_t             resp_sel_next;
    logic [DATA_WIDTH-1:0] if_hold_reg;
    logic [DATA_WIDTH-1:0] rd_hold_reg;
    logic                  promoted;
    logic                  unused_addr_bits;

    // Byte-offset bits never reach the word-addressed RAM.
    assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

    assign promoted = (if_wait_cnt_reg == 4'(MAX_IF_WAIT));

    // Reset gates the grants so nothing reaches the RAM while it is held.
    always_comb begin
        if_gnt = 1'b0;
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
        if (!reset) begin
            if (promoted && if_req) begin
                if_gnt = 1'b1;
            end else if (wr_req) begin
                wr_gnt = 1'b1;
            end else if (rd_req) begin
                rd_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en    = if_gnt | rd_gnt | wr_gnt;
        ram_addr  = '0;
        ram_wdata = '0;
        if (wr_gnt) begin
            ram_addr  = wr_addr[ADDR_WIDTH+1:2];
            ram_wdata = wr_data;
        end else if (rd_gnt) begin
            ram_addr  = rd_addr[ADDR_WIDTH+1:2];
        end else if (if_gnt) begin
            ram_addr  = if_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign ram_we[gi] = wr_gnt & wr_strb[gi];
        end
    endgenerate

    always_comb begin
        if_wait_cnt_next = if_wait_cnt_reg;
        if (!if_req || if_gnt) begin
            if_wait_cnt_next = 4'd0;
        end else if (!promoted) begin
            if_wait_cnt_next = if_wait_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        resp_sel_next = SEL_NONE;
        if (if_gnt) begin
            resp_sel_next = SEL_IF;
        end else if (rd_gnt) begin
            resp_sel_next = SEL_RD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_wait_cnt_reg <= 4'd0;
            resp_sel_reg    <= SEL_NONE;
            if_hold_reg     <= '0;
            rd_hold_reg     <= '0;
        end else begin
            if_wait_cnt_reg <= if_wait_cnt_next;
            resp_sel_reg    <= resp_sel_next;
            if (resp_sel_reg == SEL_IF) begin
                if_hold_reg <= ram_rdata;
            end
            if (resp_sel_reg == SEL_RD) begin
                rd_hold_reg <= ram_rdata;
            end
        end
    end

    // Response cycle bypasses the RAM output; otherwise replay the last word.
    assign if_rvalid = (resp_sel_reg == SEL_IF);
    assign rd_rvalid = (resp_sel_reg == SEL_RD);
    assign if_rdata  = if_rvalid ? ram_rdata : if_hold_reg;
    assign rd_rdata  = rd_rvalid ? ram_rdata : rd_hold_reg;

endmodule
